// File: rtl/clk_div_cfg_arbiter.sv
// rtl/clk_div_cfg_arbiter.sv - round-robin owner of the slow-clock divider divisor
//
// Ports:
//   i_clk       system clock, shared with the divider
//   i_rst_n     synchronous active-low reset
//   i_req       per-requester request, held high until the matching o_done
//   i_div       per-requester divisor, requester k on bits [16k+15:16k]
//   i_slow_clk  divider output, already registered in the i_clk domain
//   o_divisor   divisor driven to the divider
//   o_gnt       one-hot grant to the current owner
//   o_done      one-cycle completion pulse to the owner
//   o_busy      high whenever a transaction is in flight
//   o_timeout   sticky flag, set when an edge wait gives up
module clk_div_cfg_arbiter #(
  parameter int          NUM_REQ     = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd2,
  parameter int          TIMEOUT_CYC = 131072
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [NUM_REQ*16-1:0] i_div,
  input  logic                 i_slow_clk,
  output logic [15:0]          o_divisor,
  output logic [NUM_REQ-1:0]   o_gnt,
  output logic [NUM_REQ-1:0]   o_done,
  output logic                 o_busy,
  output logic                 o_timeout
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_EDGE,
    S_UPDATE,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t        state, state_nx;
  logic [PW-1:0] ptr;
  logic [PW-1:0] winner;
  logic [PW-1:0] cand;
  logic [PW+3:0] win_base;
  logic          found;
  logic [15:0]   cap;
  logic [15:0]   win_div;
  logic          prev;
  logic [TW-1:0] tcnt;
  logic          tog_seen;
  logic          fall;
  logic          toggle;
  logic          settle_tog;
  logic          timeout_hit;
  logic          bypass_old;
  logic          bypass_new;
  logic          settle_ok;

  assign fall        = prev & ~i_slow_clk;
  assign toggle      = prev ^ i_slow_clk;
  assign timeout_hit = (tcnt == T_LAST);
  assign bypass_old  = (o_divisor < 16'd2);
  assign bypass_new  = (cap < 16'd2);

  // The feedback is registered, so the first SETTLE cycle still reflects
  // the old rate; an edge seen there is not part of the new period.
  assign settle_tog  = toggle && (tcnt != '0);
  assign settle_ok   = settle_tog && tog_seen;

  // Round-robin search starting just above the last winner.
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    cand   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = PW'((int'(ptr) + i) % NUM_REQ);
      if (!found && i_req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign win_base = {winner, 4'b0000};
  assign win_div  = i_div[win_base +: 16];

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (found) begin
          if (win_div == o_divisor) begin
            state_nx = S_DONE;
          end else if (bypass_old) begin
            state_nx = S_UPDATE;
          end else begin
            state_nx = S_WAIT_EDGE;
          end
        end
      end
      S_WAIT_EDGE: begin
        if (fall || timeout_hit) begin
          state_nx = S_UPDATE;
        end
      end
      S_UPDATE: begin
        state_nx = bypass_new ? S_DONE : S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_ok || timeout_hit) begin
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      ptr       <= PW'(NUM_REQ - 1);
      cap       <= DEFAULT_DIV;
      o_divisor <= DEFAULT_DIV;
      prev      <= 1'b0;
      tcnt      <= '0;
      tog_seen  <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      state <= state_nx;
      prev  <= i_slow_clk;

      // Only the two edge waits need the counter; it restarts on every move.
      if ((state_nx == state) && ((state == S_WAIT_EDGE) || (state == S_SETTLE))) begin
        tcnt <= tcnt + TW'(1);
      end else begin
        tcnt <= '0;
      end

      if ((state == S_IDLE) && found) begin
        cap <= win_div;
        ptr <= winner;
      end

      if (state == S_UPDATE) begin
        o_divisor <= cap;
      end

      if (state != S_SETTLE) begin
        tog_seen <= 1'b0;
      end else if (settle_tog) begin
        tog_seen <= 1'b1;
      end

      // A real edge arriving on the last allowed cycle is not a timeout.
      if (((state == S_WAIT_EDGE) && timeout_hit && !fall) ||
          ((state == S_SETTLE) && timeout_hit && !settle_ok)) begin
        o_timeout <= 1'b1;
      end
    end
  end

  assign o_busy = (state != S_IDLE);
  assign o_gnt  = o_busy ? (NUM_REQ'(1) << ptr) : '0;
  assign o_done = (state == S_DONE) ? o_gnt : '0;

endmodule
